// File: rtl/crd_lane_sched.sv
// Round-robin share of one 8b/10b running-disparity checker across NUM_LANES lanes,
// with a per-lane RD table, saturating error counters and sticky error flags.
module crd_lane_sched #(
    parameter int NUM_LANES  = 4,
    parameter int iWIDTH     = 10,
    parameter int CNT_WIDTH  = 4,
    parameter int ERR_THRESH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_LANES-1:0]            req_valid,
    input  logic [NUM_LANES*iWIDTH-1:0]     req_data,
    output logic [NUM_LANES-1:0]            req_ready,
    input  logic [NUM_LANES-1:0]            lane_clr,
    output logic                            res_valid,
    output logic [$clog2(NUM_LANES)-1:0]    res_lane,
    output logic                            res_rd,
    output logic                            res_err,
    output logic [NUM_LANES*CNT_WIDTH-1:0]  err_cnt,
    output logic [NUM_LANES-1:0]            lane_err_sticky
);

    localparam int LW = $clog2(NUM_LANES);
    localparam int unsigned NL = NUM_LANES;
    localparam int unsigned IW = iWIDTH;
    localparam int unsigned HALF = IW / 2;
    localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(ERR_THRESH);

    typedef enum logic [1:0] {RD_UNK, RD_POS, RD_NEG} rd_e;

    logic [LW-1:0]      ptr_q, ptr_d;
    logic [LW-1:0]      gnt_lane, cand;
    logic               gnt_any;
    logic [iWIDTH-1:0]  gnt_data;

    logic               s1_valid_q;
    logic [LW-1:0]      s1_lane_q;
    logic [iWIDTH-1:0]  s1_data_q;

    rd_e                rd_tab_q [NUM_LANES];
    rd_e                rd_cur, rd_nxt;
    int unsigned        ones;
    logic               sym_eq, sym_gt, s2_err;

    logic               res_valid_q, res_rd_q, res_err_q, res_cnt_en_q;
    logic [LW-1:0]      res_lane_q;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_LANES];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_LANES];
    logic [NUM_LANES-1:0] sticky_q, sticky_d;

    // Round-robin search starting at the pointer, wrapping upward.
    always_comb begin
        req_ready = '0;
        gnt_lane  = '0;
        gnt_any   = 1'b0;
        cand      = '0;
        for (int unsigned j = 0; j < NL; j++) begin
            cand = LW'((32'(ptr_q) + j) % NL);
            if (!gnt_any && !rst && req_valid[cand]) begin
                gnt_any         = 1'b1;
                gnt_lane        = cand;
                req_ready[cand] = 1'b1;
            end
        end
    end

    assign gnt_data = req_data[gnt_lane*iWIDTH +: iWIDTH];
    assign ptr_d    = gnt_any ? LW'((32'(gnt_lane) + 1) % NL) : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_lane_q  <= '0;
            s1_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= gnt_any;
            if (gnt_any) begin
                s1_lane_q <= gnt_lane;
                s1_data_q <= gnt_data;
            end
        end
    end

    always_comb begin
        ones = 0;
        for (int unsigned b = 0; b < IW; b++) begin
            ones = ones + 32'(s1_data_q[b]);
        end
        sym_eq = (ones == HALF);
        sym_gt = (ones > HALF);
        rd_cur = rd_tab_q[s1_lane_q];
        rd_nxt = rd_cur;
        s2_err = 1'b0;
        case (rd_cur)
            RD_POS: begin
                if (sym_gt)       s2_err = 1'b1;
                else if (!sym_eq) rd_nxt = RD_NEG;
            end
            RD_NEG: begin
                if (sym_gt)       rd_nxt = RD_POS;
                else if (!sym_eq) s2_err = 1'b1;
            end
            default: rd_nxt = (sym_gt || sym_eq) ? RD_POS : RD_NEG;
        endcase
    end

    // A lane clear lands after the S2 write so it wins for that lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NL; i++) rd_tab_q[i] <= RD_UNK;
        end else begin
            if (s1_valid_q) rd_tab_q[s1_lane_q] <= rd_nxt;
            for (int unsigned i = 0; i < NL; i++) begin
                if (lane_clr[i]) rd_tab_q[i] <= RD_UNK;
            end
        end
    end

    // cnt_en drops when the lane was cleared while this symbol sat in S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_lane_q   <= '0;
            res_rd_q     <= 1'b0;
            res_err_q    <= 1'b0;
            res_cnt_en_q <= 1'b0;
        end else begin
            res_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_lane_q   <= s1_lane_q;
                res_rd_q     <= (rd_nxt == RD_POS);
                res_err_q    <= s2_err;
                res_cnt_en_q <= !lane_clr[s1_lane_q];
            end else begin
                res_lane_q   <= '0;
                res_rd_q     <= 1'b0;
                res_err_q    <= 1'b0;
                res_cnt_en_q <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NL; i++) begin
            cnt_d[i] = cnt_q[i];
            if (res_valid_q && res_err_q && res_cnt_en_q &&
                res_lane_q == LW'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            sticky_d[i] = sticky_q[i] | (cnt_d[i] >= THRESH);
            if (lane_clr[i]) begin
                cnt_d[i]    = '0;
                sticky_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NL; i++) cnt_q[i] <= '0;
            sticky_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_cnt_out
        assign err_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

    assign lane_err_sticky = sticky_q;
    assign res_valid       = res_valid_q;
    assign res_lane        = res_lane_q;
    assign res_rd          = res_rd_q;
    assign res_err         = res_err_q;

endmodule

// File: tb/tb_crd_lane_sched.sv
// Bench for crd_lane_sched: vector table, directed corner sequences and
// randomized traffic checked against a transaction-level disparity model.
module tb_crd_lane_sched;

    localparam int NL  = 4;
    localparam int W   = 10;
    localparam int CW  = 4;
    localparam int THR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NL-1:0]     req_valid, req_ready, lane_clr, sticky;
    logic [NL*W-1:0]   req_data;
    logic              res_valid, res_rd, res_err;
    logic [1:0]        res_lane;
    logic [NL*CW-1:0]  err_cnt;

    always #5 clk = ~clk;

    crd_lane_sched #(
        .NUM_LANES (NL),
        .iWIDTH    (W),
        .CNT_WIDTH (CW),
        .ERR_THRESH(THR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .lane_clr       (lane_clr),
        .res_valid      (res_valid),
        .res_lane       (res_lane),
        .res_rd         (res_rd),
        .res_err        (res_err),
        .err_cnt        (err_cnt),
        .lane_err_sticky(sticky)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: symbols queued with their transfer cycle; a symbol is
    // judged against its lane's disparity one cycle later, reported the next.
    typedef struct { int lane; logic [W-1:0] data; int t; } xfer_t;
    typedef struct { int lane; bit rd; bit err; bit cnt_en; int t; } res_t;

    xfer_t xq[$];
    res_t  rq[$];
    int    rd_m  [NL];   // 0 unknown, +1 positive, -1 negative
    int    cnt_m [NL];
    bit    stk_m [NL];
    int    ptr_m;
    int    t_now;
    logic [NL-1:0] exp_ready;
    bit    have_res;

    function automatic logic [NL-1:0] arb(input int p, input logic [NL-1:0] v);
        for (int k = 0; k < NL; k++) begin
            int l;
            l = (p + k) % NL;
            if (v[l]) return NL'(1) << l;
        end
        return '0;
    endfunction

    task automatic model_clear();
        xq.delete();
        rq.delete();
        for (int i = 0; i < NL; i++) begin
            rd_m[i] = 0; cnt_m[i] = 0; stk_m[i] = 0;
        end
        ptr_m = 0;
    endtask

    task automatic sample();
        logic [NL*CW-1:0] ec;
        logic [NL-1:0]    es;
        @(negedge clk);
        exp_ready = rst ? '0 : arb(ptr_m, req_valid);
        chk("req_ready", req_ready, exp_ready);
        have_res = (rq.size() > 0) && (rq[0].t == t_now);
        chk("res_valid", res_valid, have_res);
        if (have_res && res_valid) begin
            chk("res_lane", res_lane, rq[0].lane);
            chk("res_rd", res_rd, rq[0].rd);
            chk("res_err", res_err, rq[0].err);
        end
        for (int i = 0; i < NL; i++) begin
            ec[i*CW +: CW] = CW'(cnt_m[i]);
            es[i]          = stk_m[i];
        end
        chk("err_cnt", err_cnt, ec);
        chk("sticky", sticky, es);
    endtask

    task automatic advance();
        res_t  r;
        xfer_t x;
        int    d, nrd, g;
        bit    e;
        if (rst) begin
            model_clear();
        end else begin
            if (have_res) begin
                r = rq.pop_front();
                if (r.err && r.cnt_en) begin
                    if (cnt_m[r.lane] < (1 << CW) - 1) cnt_m[r.lane]++;
                    if (cnt_m[r.lane] >= THR) stk_m[r.lane] = 1;
                end
            end
            if (xq.size() > 0 && xq[0].t == t_now - 1) begin
                x = xq.pop_front();
                d = $countones(x.data) - W / 2;
                if (rd_m[x.lane] == 0) begin
                    nrd = (d >= 0) ? 1 : -1; e = 0;
                end else if (d == 0) begin
                    nrd = rd_m[x.lane]; e = 0;
                end else begin
                    nrd = (d > 0) ? 1 : -1;
                    e   = (nrd == rd_m[x.lane]);
                end
                rd_m[x.lane] = nrd;
                rq.push_back('{x.lane, nrd > 0, e, !lane_clr[x.lane], t_now + 1});
            end
            for (int i = 0; i < NL; i++) begin
                if (lane_clr[i]) begin
                    rd_m[i] = 0; cnt_m[i] = 0; stk_m[i] = 0;
                end
            end
            if (exp_ready != '0) begin
                g = 0;
                for (int i = 0; i < NL; i++) if (exp_ready[i]) g = i;
                xq.push_back('{g, req_data[g*W +: W], t_now});
                ptr_m = (g + 1) % NL;
            end
        end
        t_now++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; lane_clr = '0;
        step(1);
        rst = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic [NL-1:0] valid;
        logic [W-1:0]  data;
        logic [NL-1:0] rdy;
        logic          rv;
        logic [1:0]    lane;
        logic          rd;
        logic          err;
        logic [CW-1:0] cnt0;
    } vec_t;

    vec_t tab[16];
    logic [W-1:0] pats[6];

    initial begin
        tab = '{
            '{1'b0, 4'b0001, 10'b1111100000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0},
            '{1'b0, 4'b0001, 10'b1111110000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0},
            '{1'b0, 4'b0001, 10'b1111000000, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 4'd0},
            '{1'b0, 4'b0000, 10'b1111000000, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 4'd0},
            '{1'b0, 4'b0000, 10'b1111000000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, 4'd1},
            '{1'b0, 4'b0000, 10'b1111000000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 4'd1},
            '{1'b1, 4'b0000, 10'b1111100000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 4'd1},
            '{1'b0, 4'b1111, 10'b1111100000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0},
            '{1'b0, 4'b1111, 10'b1111100000, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0},
            '{1'b0, 4'b1111, 10'b1111100000, 4'b0100, 1'b1, 2'd0, 1'b1, 1'b0, 4'd0},
            '{1'b0, 4'b1111, 10'b1111100000, 4'b1000, 1'b1, 2'd1, 1'b1, 1'b0, 4'd0},
            '{1'b0, 4'b1111, 10'b1111100000, 4'b0001, 1'b1, 2'd2, 1'b1, 1'b0, 4'd0},
            '{1'b0, 4'b1111, 10'b1111100000, 4'b0010, 1'b1, 2'd3, 1'b1, 1'b0, 4'd0},
            '{1'b0, 4'b0000, 10'b1111100000, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 4'd0},
            '{1'b0, 4'b0000, 10'b1111100000, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0, 4'd0},
            '{1'b0, 4'b0000, 10'b1111100000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0}
        };
        pats = '{10'b1111100000, 10'b1111110000, 10'b1111000000,
                 10'b1010101010, 10'b0000011111, 10'b1100111100};

        rst = 1'b1; req_valid = '0; lane_clr = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        t_now = 0;

        // Reset values of the result port.
        @(negedge clk);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_lane", res_lane, 2'd0);
        chk("rst_res_rd", res_rd, 1'b0);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_err_cnt", err_cnt, '0);
        chk("rst_sticky", sticky, '0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 16; k++) begin
            rst       = tab[k].rst;
            req_valid = tab[k].valid;
            req_data  = {NL{tab[k].data}};
            lane_clr  = '0;
            sample();
            chk("tab_ready", req_ready, tab[k].rdy);
            chk("tab_res_valid", res_valid, tab[k].rv);
            if (tab[k].rv) begin
                chk("tab_res_lane", res_lane, tab[k].lane);
                chk("tab_res_rd", res_rd, tab[k].rd);
                chk("tab_res_err", res_err, tab[k].err);
            end
            chk("tab_cnt0", err_cnt[CW-1:0], tab[k].cnt0);
            advance();
        end

        // Lane 2: one 4-ones symbol then four more, each a disparity error.
        do_reset();
        req_valid = 4'b0100;
        req_data  = {NL{10'b1111000000}};
        for (int c = 0; c < 8; c++) begin
            sample();
            if (c == 6) begin
                chk("thr_cnt_before", err_cnt[2*CW +: CW], 4'd3);
                chk("thr_sticky_before", sticky[2], 1'b0);
            end
            if (c == 7) begin
                chk("thr_cnt_after", err_cnt[2*CW +: CW], 4'd4);
                chk("thr_sticky_after", sticky[2], 1'b1);
            end
            advance();
            if (c == 4) req_valid = '0;
        end

        // Lane clear while lane 1 has an error symbol in S2.
        do_reset();
        req_valid = 4'b0010;
        req_data  = {NL{10'b1111000000}};
        for (int c = 0; c < 6; c++) begin
            lane_clr = (c == 2) ? 4'b0010 : 4'b0000;
            if (c == 3) req_valid = '0;
            sample();
            if (c == 3) begin
                chk("clr_res_valid", res_valid, 1'b1);
                chk("clr_res_err", res_err, 1'b1);
            end
            if (c == 4) begin
                chk("clr_unk_rd", res_rd, 1'b0);
                chk("clr_unk_err", res_err, 1'b0);
            end
            if (c == 5) begin
                chk("clr_cnt1", err_cnt[CW +: CW], 4'd0);
                chk("clr_sticky1", sticky[1], 1'b0);
            end
            advance();
        end
        lane_clr = '0;

        // Reset with two lane-1 symbols in flight.
        do_reset();
        req_valid = 4'b0010;
        req_data  = {NL{10'b1111000000}};
        step(2);
        rst = 1'b1; req_valid = 4'b1111;
        step(1);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sample();
            chk("rst_mid_res_valid", res_valid, 1'b0);
            chk("rst_mid_cnt", err_cnt, '0);
            if (c == 0) chk("rst_mid_ptr", req_ready, 4'b0001);
            advance();
        end
        req_valid = '0;
        step(3);

        // Counter saturation: 17 errors on lane 0.
        do_reset();
        req_valid = 4'b0001;
        req_data  = {NL{10'b1111000000}};
        step(18);
        req_valid = '0;
        step(4);
        chk("sat_cnt0", err_cnt[CW-1:0], 4'hF);
        chk("sat_sticky0", sticky[0], 1'b1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_valid = NL'($urandom);
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 3) == 0) req_data[i*W +: W] = W'($urandom);
                else req_data[i*W +: W] = pats[$urandom_range(0, 5)];
            end
            lane_clr = ($urandom_range(0, 19) == 0) ? (NL'(1) << $urandom_range(0, NL - 1)) : '0;
            step(1);
        end
        rst = 1'b0; req_valid = '0; lane_clr = '0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
